// File: rtl/rr_mux_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_pkg: shared constants and helpers for rr_mux_reg / rr_pick. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rr_mux_pkg;

  // Reset values; wide enough for any practical WIDTH/SELW and cast down at use.
  localparam logic [63:0] DATA_RST = 64'h0;
  localparam logic [31:0] SEL_RST  = 32'h0;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  // LSB position of channel k inside a flattened N*width bus.
  function automatic int chan_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick: combinational round-robin picker, first valid at/after ptr (wrapping). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import rr_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [SELW-1:0] ptr,
  input  logic            force_en,
  input  logic [SELW-1:0] force_ch,
  output logic [SELW-1:0] g,
  output logic            any
);

  int idx;

  always_comb begin
    g   = ptr;
    any = 1'b0;
    idx = 0;
    if (force_en) begin
      g   = force_ch;
      any = valid[force_ch];
    end else begin
      any = |valid;
      // Walk offsets high to low so the smallest offset from ptr wins.
      for (int i = N - 1; i >= 0; i--) begin
        idx = int'(ptr) + i;
        if (idx >= N) idx = idx - N;
        if (valid[idx]) g = SELW'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux_reg.sv
// ---------------------------------------------------------------------------
// rr_mux_reg: N-channel round-robin mux with registered valid/ready output;
// define RR_MUX_HOLD_EN to lock the grant on a source until its last beat. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_mux_reg
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = clog2(N)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N-1:0]       valid_i,
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [N-1:0]       last_i,
  output logic [N-1:0]       ready_o,
  output logic               valid_o,
  output logic [WIDTH-1:0]   data_o,
  output logic [SELW-1:0]    sel_o,
  output logic               last_o,
  input  logic               ready_i
);

  logic             ld;
  logic             any;
  logic [SELW-1:0]  g;
  logic [SELW-1:0]  ptr;
  logic             force_en;
  logic [SELW-1:0]  force_ch;
  logic [WIDTH-1:0] chan_data [N];

  assign ld = !valid_o || ready_i;

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan_data[k] = data_i[chan_lsb(k, WIDTH) +: WIDTH];
    assign ready_o[k]   = ld && any && (g == SELW'(k));
  end

`ifdef RR_MUX_HOLD_EN
  logic            lock_vld;
  logic [SELW-1:0] lock_ch;

  assign force_en = lock_vld;
  assign force_ch = lock_ch;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lock_vld <= 1'b0;
      lock_ch  <= SELW'(SEL_RST);
    end else if (ld && any) begin
      // While locked g is already lock_ch, so a last beat here ends the packet.
      if (last_i[g]) begin
        lock_vld <= 1'b0;
      end else begin
        lock_vld <= 1'b1;
        lock_ch  <= g;
      end
    end
  end
`else
  assign force_en = 1'b0;
  assign force_ch = '0;
`endif

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .valid    (valid_i),
    .ptr      (ptr),
    .force_en (force_en),
    .force_ch (force_ch),
    .g        (g),
    .any      (any)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o <= 1'b0;
      data_o  <= WIDTH'(DATA_RST);
      sel_o   <= SELW'(SEL_RST);
      last_o  <= 1'b0;
      ptr     <= '0;
    end else if (ld) begin
      if (any) begin
        valid_o <= 1'b1;
        data_o  <= chan_data[g];
        sel_o   <= g;
        last_o  <= last_i[g];
        ptr     <= (g == SELW'(N - 1)) ? '0 : g + 1'b1;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_reg.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_reg: directed + random checks of rr_mux_reg against a queue-free
// behavioural model (N=4) and fixed expectations for an N=3 instance. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_rr_mux_reg;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int W3 = 8;
  localparam int N3 = 3;
  localparam int SW3 = 2;
`ifdef RR_MUX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   valid;
  logic [N*W-1:0] data;
  logic [N-1:0]   last;
  logic           ready;
  logic [N-1:0]   ready_o;
  logic           valid_o;
  logic [W-1:0]   data_o;
  logic [SW-1:0]  sel_o;
  logic           last_o;

  logic [N3-1:0]    valid3;
  logic [N3*W3-1:0] data3;
  logic [N3-1:0]    last3;
  logic             ready3;
  logic [N3-1:0]    ready3_o;
  logic             valid3_o;
  logic [W3-1:0]    data3_o;
  logic [SW3-1:0]   sel3_o;
  logic             last3_o;

  rr_mux_reg #(.WIDTH(W), .N(N)) dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .data_i(data), .last_i(last),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .sel_o(sel_o),
    .last_o(last_o), .ready_i(ready)
  );

  rr_mux_reg #(.WIDTH(W3), .N(N3)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid3), .data_i(data3), .last_i(last3),
    .ready_o(ready3_o), .valid_o(valid3_o), .data_o(data3_o), .sel_o(sel3_o),
    .last_o(last3_o), .ready_i(ready3)
  );

  int total = 0;
  int bad = 0;

  // Reference model state for the N=4 instance.
  bit           m_vld;
  logic [W-1:0] m_data;
  int           m_sel;
  bit           m_last;
  int           m_ptr;
  bit           m_lock;
  int           m_lock_ch;
  int           last_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_vld = 0; m_data = '0; m_sel = 0; m_last = 0;
    m_ptr = 0; m_lock = 0; m_lock_ch = 0;
  endfunction

  function automatic void m_grant(output bit any, output int g);
    any = 0;
    g = 0;
    if (m_lock) begin
      any = valid[m_lock_ch];
      g = m_lock_ch;
    end else begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (!any && valid[k]) begin
          any = 1;
          g = k;
        end
      end
    end
  endfunction

  // Inputs are already applied; checks ready_o, clocks once, checks outputs.
  task automatic step();
    bit any;
    int g;
    bit ld;
    logic [N-1:0] one;
    logic [N-1:0] exp_rdy;
    #1;
    m_grant(any, g);
    ld = !m_vld || ready;
    one = 1;
    exp_rdy = (ld && any) ? (one << g) : '0;
    chk("ready_o", ready_o, exp_rdy);
    last_grant = (ld && any) ? g : -1;
    @(posedge clk);
    if (ld) begin
      if (any) begin
        m_vld = 1;
        m_data = data[g*W +: W];
        m_sel = g;
        m_last = last[g];
        m_ptr = (g + 1) % N;
        if (HOLD) begin
          if (last[g]) m_lock = 0;
          else begin
            m_lock = 1;
            m_lock_ch = g;
          end
        end
      end else begin
        m_vld = 0;
      end
    end
    #1;
    chk("valid_o", valid_o, m_vld);
    chk("data_o", data_o, m_data);
    chk("sel_o", sel_o, m_sel);
    chk("last_o", last_o, m_last);
  endtask

  task automatic step3(input int exp_sel);
    logic [W3-1:0] base;
    base = 8'h30;
    @(posedge clk);
    #1;
    chk("n3_valid", valid3_o, 1'b1);
    chk("n3_sel", sel3_o, exp_sel);
    chk("n3_data", data3_o, base + exp_sel);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    m_reset();
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_data", data_o, '0);
    chk("rst_sel", sel_o, '0);
    chk("rst_last", last_o, 1'b0);
    #2;
    rst_n = 1;
  endtask

  int exp_seq [5];
  int rem2;

  initial begin
    valid = '1; last = '1; ready = 1; data = '0;
    valid3 = '0; last3 = '1; ready3 = 1;
    for (int k = 0; k < N3; k++) data3[k*W3 +: W3] = W3'(8'h30 + k);
    m_reset();

    // Reset held over clock edges with all channels requesting.
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_data", data_o, '0);
    chk("rst_sel", sel_o, '0);
    #2 rst_n = 1;

    // Full rotation with constant expectations.
    for (int k = 0; k < N; k++) data[k*W +: W] = W'(32'hA0 + k);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rot_sel", sel_o, i % N);
      chk("rot_data", data_o, 32'hA0 + (i % N));
    end

    // Backpressure while holding A1, then reload with no bubble.
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_data", data_o, 32'hA1);
      chk("bp_rdy", ready_o, '0);
    end
    ready = 1;
    step();
    chk("bp_next", data_o, 32'hA2);

    // Sparse: one beat on channel 1 then idle.
    valid = 4'b0010;
    step();
    chk("sp_vld1", valid_o, 1'b1);
    valid = 4'b0000;
    step();
    chk("sp_vld0", valid_o, 1'b0);
    chk("sp_hold", data_o, 32'hA1);

    // Packet test: move ptr to 2, then ch2 sends 3 beats while ch0 always valid.
    do_reset();
    valid = 4'b0010;
    step();
    rem2 = 3;
    if (HOLD) exp_seq = '{2, 2, 2, 0, 0};
    else      exp_seq = '{2, 0, 2, 0, 2};
    for (int i = 0; i < 5; i++) begin
      valid = {1'b0, rem2 > 0, 1'b0, 1'b1};
      last = {1'b1, rem2 == 1, 1'b1, 1'b1};
      step();
      chk("pkt_grant", last_grant, exp_seq[i]);
      if (last_grant == 2) rem2--;
    end

    // Random traffic with one asynchronous reset mid-stream.
    for (int i = 0; i < 400; i++) begin
      valid = N'($urandom);
      last = N'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      data = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      if (i == 200) do_reset();
    end

    // N=3 instance: wrap from ptr=2 and non-power-of-two rotation.
    valid = '0;
    ready = 1;
    valid3 = 3'b010; step3(1);
    valid3 = 3'b001; step3(0);
    valid3 = 3'b111; step3(1);
    valid3 = 3'b101; step3(2);
    valid3 = 3'b101; step3(0);
    valid3 = 3'b000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
